// File: rtl/axist_rand_chk.sv
// AXI-ST receive checker: regenerates the leader's LFSR stream from the seed and scores each accepted beat.
// s_tready is combinational from state and stall_in; results update on the accepting edge; idle/done beats are refused.
module axist_rand_chk #(
    parameter int LEADER_MODE = 1,
    parameter int CNT_W       = 16,
    localparam int DW         = LEADER_MODE * 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chk_start,
    input  logic [DW-1:0]    seed_in,
    input  logic [CNT_W-1:0] num_beats,
    input  logic             stall_in,
    input  logic             s_tvalid,
    input  logic [DW-1:0]    s_tdata,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic             chk_busy,
    output logic             chk_done,
    output logic             chk_pass,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             tlast_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    // Tap positions for the two supported polynomials; unsupported modes shift in zeros.
    localparam bit TAPS_OK = (LEADER_MODE == 1) || (LEADER_MODE == 2);
    localparam int T0 = (LEADER_MODE == 2) ? 79 : 39;
    localparam int T1 = (LEADER_MODE == 2) ? 78 : 37;
    localparam int T2 = (LEADER_MODE == 2) ? 42 : 20;
    localparam int T3 = (LEADER_MODE == 2) ? 41 : 18;

    state_t           state_q, state_d;
    logic [DW-1:0]    exp_q, exp_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic             tle_q, tle_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic fb;
    logic accept;
    logic is_last;

    assign s_tready = (state_q == ST_RUN) & ~stall_in;
    assign accept   = s_tvalid & s_tready;
    assign is_last  = (beat_q == (num_q - CNT_W'(1)));
    assign fb       = TAPS_OK & (exp_q[T0] ^ exp_q[T1] ^ exp_q[T2] ^ exp_q[T3]);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        num_d   = num_q;
        beat_d  = beat_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        tle_d   = tle_q;
        done_d  = done_q;
        pass_d  = pass_q;
        if (chk_start) begin
            // A start in any state reloads the run; an in-flight beat is dropped.
            exp_d   = seed_in;
            num_d   = num_beats;
            beat_d  = '0;
            err_d   = '0;
            fidx_d  = '1;
            tle_d   = 1'b0;
            done_d  = (num_beats == '0);
            pass_d  = (num_beats == '0);
            state_d = (num_beats == '0) ? ST_DONE : ST_RUN;
        end else if (accept) begin
            exp_d  = {exp_q[DW-2:0], fb};
            beat_d = beat_q + CNT_W'(1);
            if (s_tdata != exp_q) begin
                if (err_q != '1) begin
                    err_d = err_q + CNT_W'(1);
                end
                if (err_q == '0) begin
                    fidx_d = beat_q;
                end
            end
            if (s_tlast != is_last) begin
                tle_d = 1'b1;
            end
            if (is_last) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                pass_d  = (err_d == '0) & ~tle_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            exp_q   <= DW'(1);
            num_q   <= '0;
            beat_q  <= '0;
            err_q   <= '0;
            fidx_q  <= '1;
            tle_q   <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            num_q   <= num_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            tle_q   <= tle_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign chk_busy      = (state_q == ST_RUN);
    assign chk_done      = done_q;
    assign chk_pass      = pass_q;
    assign beat_cnt      = beat_q;
    assign err_cnt       = err_q;
    assign first_err_idx = fidx_q;
    assign tlast_err     = tle_q;

endmodule

// File: tb/tb_axist_rand_chk.sv
// Bench: FULL and HALF checkers driven in lockstep, each fed its own LFSR stream.
// Directed table vectors, reset/restart/done sequences, and randomized runs scored by a beat-level model.
module tb_axist_rand_chk;

    logic        clk;
    logic        rst_n;
    logic        chk_start;
    logic [15:0] num_beats;
    logic        stall_in;
    logic        s_tvalid;
    logic        s_tlast;
    logic [39:0] seed_f, s_tdata_f;
    logic [79:0] seed_h, s_tdata_h;
    logic        rdy_f, busy_f, done_f, pass_f, tle_f;
    logic        rdy_h, busy_h, done_h, pass_h, tle_h;
    logic [15:0] beat_f, err_f, fidx_f;
    logic [15:0] beat_h, err_h, fidx_h;

    int n_err;
    int n_chk;

    axist_rand_chk #(.LEADER_MODE(1), .CNT_W(16)) u_full (
        .clk(clk), .rst_n(rst_n), .chk_start(chk_start), .seed_in(seed_f),
        .num_beats(num_beats), .stall_in(stall_in), .s_tvalid(s_tvalid),
        .s_tdata(s_tdata_f), .s_tlast(s_tlast), .s_tready(rdy_f),
        .chk_busy(busy_f), .chk_done(done_f), .chk_pass(pass_f),
        .beat_cnt(beat_f), .err_cnt(err_f), .first_err_idx(fidx_f), .tlast_err(tle_f)
    );

    axist_rand_chk #(.LEADER_MODE(2), .CNT_W(16)) u_half (
        .clk(clk), .rst_n(rst_n), .chk_start(chk_start), .seed_in(seed_h),
        .num_beats(num_beats), .stall_in(stall_in), .s_tvalid(s_tvalid),
        .s_tdata(s_tdata_h), .s_tlast(s_tlast), .s_tready(rdy_h),
        .chk_busy(busy_h), .chk_done(done_h), .chk_pass(pass_h),
        .beat_cnt(beat_h), .err_cnt(err_h), .first_err_idx(fidx_h), .tlast_err(tle_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Generator streams, straight from the polynomial definitions.
    function automatic logic [39:0] nxt_f(input logic [39:0] x);
        return {x[38:0], x[39] ^ x[37] ^ x[20] ^ x[18]};
    endfunction

    function automatic logic [79:0] nxt_h(input logic [79:0] x);
        return {x[78:0], x[79] ^ x[78] ^ x[42] ^ x[41]};
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_pair(input string tag, input bit e_busy, input bit e_done, input bit e_pass,
                            input bit e_tle, input int e_beat, input int e_err, input int e_fidx);
        logic [15:0] fx;
        fx = (e_fidx < 0) ? 16'hFFFF : e_fidx[15:0];
        chk({tag, ".F.busy"}, busy_f, e_busy);
        chk({tag, ".F.done"}, done_f, e_done);
        chk({tag, ".F.pass"}, pass_f, e_pass);
        chk({tag, ".F.tlast_err"}, tle_f, e_tle);
        chk({tag, ".F.beat_cnt"}, beat_f, e_beat[15:0]);
        chk({tag, ".F.err_cnt"}, err_f, e_err[15:0]);
        chk({tag, ".F.first_err"}, fidx_f, fx);
        chk({tag, ".H.busy"}, busy_h, e_busy);
        chk({tag, ".H.done"}, done_h, e_done);
        chk({tag, ".H.pass"}, pass_h, e_pass);
        chk({tag, ".H.tlast_err"}, tle_h, e_tle);
        chk({tag, ".H.beat_cnt"}, beat_h, e_beat[15:0]);
        chk({tag, ".H.err_cnt"}, err_h, e_err[15:0]);
        chk({tag, ".H.first_err"}, fidx_h, fx);
    endtask

    // Starts a run and offers n_send beats; the model scores each beat as it is accepted.
    task automatic run(input int nb, input int n_send, input logic [79:0] seed, input int corrupt,
                       input int tlast_idx, input int stall_mode, input int gaps, input bit rand_err,
                       output int m_err, output int m_fidx, output bit m_tle);
        logic [39:0] ef;
        logic [79:0] eh;
        logic [79:0] mask;
        int          i;
        int          cyc;
        bit          c_cur, t_cur, new_beat, tog, acc;
        m_err = 0; m_fidx = -1; m_tle = 0;
        @(negedge clk);
        chk_start = 1'b1; num_beats = nb[15:0]; seed_f = seed[39:0]; seed_h = seed;
        s_tvalid = 1'b0; stall_in = 1'b0;
        @(negedge clk);
        chk_start = 1'b0;
        ef = seed[39:0]; eh = seed; i = 0; cyc = 0; tog = 0; new_beat = 1;
        c_cur = 0; t_cur = 0; mask = 80'h1;
        while (i < n_send && cyc < 8 * n_send + 50) begin
            cyc++;
            if (new_beat) begin
                c_cur = (i == corrupt) || (rand_err && $urandom_range(0, 15) == 0);
                t_cur = (i == tlast_idx) ^ (rand_err && $urandom_range(0, 63) == 0);
                mask  = rand_err ? ({16'($urandom), $urandom, $urandom} | 80'h1) : 80'h1;
                new_beat = 0;
            end
            s_tvalid  = (gaps != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_tdata_f = s_tvalid ? (c_cur ? ef ^ mask[39:0] : ef) : 40'($urandom);
            s_tdata_h = s_tvalid ? (c_cur ? eh ^ mask : eh) : {16'($urandom), $urandom, $urandom};
            s_tlast   = s_tvalid ? t_cur : 1'($urandom_range(0, 1));
            case (stall_mode)
                1:       begin stall_in = tog; tog = ~tog; end
                2:       stall_in = ($urandom_range(0, 3) == 0);
                default: stall_in = 1'b0;
            endcase
            #1;
            if (stall_in) begin
                chk("stall.rdy_f", rdy_f, 0);
                chk("stall.rdy_h", rdy_h, 0);
            end
            acc = s_tvalid && rdy_f;
            @(negedge clk);
            if (acc) begin
                if (c_cur) begin
                    m_err++;
                    if (m_fidx < 0) m_fidx = i;
                end
                if (t_cur != (i == nb - 1)) m_tle = 1;
                ef = nxt_f(ef); eh = nxt_h(eh);
                i++; new_beat = 1;
            end
        end
        if (i < n_send) begin
            n_chk++; n_err++;
            $display("FAIL run.timeout: accepted %0d beats required %0d", i, n_send);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; stall_in = 1'b0;
    endtask

    typedef struct {
        int nb; logic [39:0] seed; int corrupt; int tlast_idx; int stall_mode; int gaps;
        int e_beat; int e_err; int e_fidx; bit e_tle; bit e_pass;
    } vec_t;

    vec_t vt[7];

    initial begin
        int me, mf, nb;
        bit mt;
        logic [79:0] rs;
        n_err = 0; n_chk = 0;
        rst_n = 1'b0; chk_start = 1'b0; num_beats = '0; stall_in = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b0; seed_f = '0; seed_h = '0; s_tdata_f = '0; s_tdata_h = '0;

        //            nb  seed              corr tlast stall gaps beat err fidx tle pass
        vt[0] = '{3, 40'h1,            -1,  2,   0,    0,   3,   0,  -1,  0,  1};
        vt[1] = '{4, 40'h1,             2,  3,   0,    0,   4,   1,   2,  0,  0};
        vt[2] = '{3, 40'h1,            -1,  2,   1,    1,   3,   0,  -1,  0,  1};
        vt[3] = '{3, 40'h1,            -1,  1,   0,    0,   3,   0,  -1,  1,  0};
        vt[4] = '{0, 40'h1,            -1, -1,   0,    0,   0,   0,  -1,  0,  1};
        vt[5] = '{5, 40'hA5_5A5A_0F0F,  0,  4,   2,    1,   5,   1,   0,  0,  0};
        vt[6] = '{2, 40'h3C,            1,  0,   0,    0,   2,   1,   1,  1,  0};

        repeat (2) @(negedge clk);
        chk_pair("reset", 0, 0, 0, 0, 0, 0, -1);
        chk("reset.rdy_f", rdy_f, 0);
        chk("reset.rdy_h", rdy_h, 0);
        rst_n = 1'b1;

        foreach (vt[k]) begin
            run(vt[k].nb, vt[k].nb, {40'h0, vt[k].seed}, vt[k].corrupt, vt[k].tlast_idx,
                vt[k].stall_mode, vt[k].gaps, 1'b0, me, mf, mt);
            chk_pair($sformatf("vec%0d", k), 0, 1, vt[k].e_pass, vt[k].e_tle,
                     vt[k].e_beat, vt[k].e_err, vt[k].e_fidx);
        end

        // Beats offered after completion are refused and leave the results alone.
        run(3, 3, 80'h1, -1, 2, 0, 0, 1'b0, me, mf, mt);
        repeat (3) begin
            @(negedge clk);
            s_tvalid = 1'b1; s_tdata_f = 40'h8; s_tdata_h = 80'h8; s_tlast = 1'b1;
            #1;
            chk("done.rdy_f", rdy_f, 0);
            chk("done.rdy_h", rdy_h, 0);
        end
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        chk_pair("done_hold", 0, 1, 1, 0, 3, 0, -1);

        // Restart mid-run clears a corrupted partial run.
        run(4, 2, 80'h1, 0, 3, 0, 0, 1'b0, me, mf, mt);
        chk_pair("partial", 1, 0, 0, 0, 2, 1, 0);
        run(3, 3, 80'h7, -1, 2, 0, 0, 1'b0, me, mf, mt);
        chk_pair("restart", 0, 1, 1, 0, 3, 0, -1);

        // Reset after two of five beats, then a clean short run.
        run(5, 2, 80'h1, -1, 4, 0, 0, 1'b0, me, mf, mt);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_pair("midreset", 0, 0, 0, 0, 0, 0, -1);
        chk("midreset.rdy_f", rdy_f, 0);
        rst_n = 1'b1;
        run(3, 3, 80'h1, -1, 2, 0, 0, 1'b0, me, mf, mt);
        chk_pair("postreset", 0, 1, 1, 0, 3, 0, -1);

        // Long clean run from a random seed.
        rs = {16'($urandom), $urandom, $urandom} | 80'h1;
        run(1000, 1000, rs, -1, 999, 2, 1, 1'b0, me, mf, mt);
        chk_pair("long", 0, 1, 1, 0, 1000, 0, -1);

        // Random runs with sporadic data and tlast faults, scored by the model.
        for (int r = 0; r < 8; r++) begin
            nb = $urandom_range(1, 40);
            rs = {16'($urandom), $urandom, $urandom} | 80'h1;
            run(nb, nb, rs, -1, nb - 1, $urandom_range(0, 2), $urandom_range(0, 1), 1'b1, me, mf, mt);
            chk_pair($sformatf("rand%0d", r), 0, 1, (me == 0) && !mt, mt, nb, me, mf);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
